ahb_burst_addr_gen: RTL
=======================

# ahb_burst_addr_gen

AHB master-side address-phase sequencer. It accepts one burst request at a time, described by start address, HBURST, HSIZE and length. It drives the AHB address-phase signals HTRANS, HADDR, HBURST and HSIZE beat by beat, honouring HREADY back-pressure. It sits directly upstream of the AHB arbiter/interconnect, and uses the package-wide HTRANS/HSIZE/HBURST encodings (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11; BYTE/HALF_WORD/WORD = 0/1/2; SINGLE..INCR16 = 0..7).

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data bus width; HSIZE above WORD is illegal

- HCLK  in  1  clock, all state on rising edge
- HRESET  in  1  asynchronous, active-high reset
- req_valid  in  1  burst request present
- req_ready  out  1  block can accept a request
- req_addr  in  ADDR_WIDTH  start address
- req_burst  in  3  HBURST encoding
- req_size  in  3  HSIZE encoding
- req_len  in  8  beat count, used only for INCR (1..255; 0 illegal)
- stall  in  1  request BUSY insertion on the next SEQ beat
- HREADY  in  1  bus ready; address phase advances only when 1
- HTRANS  out  2  transfer type
- HADDR  out  ADDR_WIDTH  address
- HBURST  out  3  burst type of current burst
- HSIZE  out  3  transfer size
- beat_idx  out  8  index of beat on HADDR, 0-based
- done  out  1  one-cycle pulse, last beat accepted
- req_err  out  1  one-cycle pulse, request rejected

## Operation
- **States:** IDLE, ACTIVE.
- **IDLE:**
  - req_ready=1, HTRANS=IDLE.
  - A request is accepted on an edge where req_valid=1.
- **Validation at acceptance:**
  - An error occurs if req_size>2, or req_addr is not aligned to 1<<req_size, or req_burst=INCR with req_len=0.
  - On error: req_err=1 for the next cycle, the FSM stays in IDLE, and no transfer is issued.
- **Beat count:**
  - SINGLE=1, INCR=req_len.
  - INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16.
- **ACTIVE entry:** the first beat drives HTRANS=NONSEQ, HADDR=req_addr, beat_idx=0.
- **Beat advance:** on an edge with HREADY=1 and beats remaining:
  - beat_idx increments.
  - inc = 1<<HSIZE.
  - INCRx/INCR: next = addr+inc.
  - WRAPx: bound = beats·inc; next = (addr & ~(bound-1)) | ((addr+inc) & (bound-1)).
- **Fixed INCRx:** a fixed INCRx whose span crosses a 1 KB boundary is rejected as req_err.
- **INCR (undefined length):** when next crosses into a new 1 KB page (next[9:0]==0), that beat is driven as NONSEQ (HBURST stays INCR). Otherwise it is driven as SEQ.
- **BUSY insertion:**
  - When the next beat would be SEQ and stall=1 at that edge, the block drives HTRANS=BUSY with HADDR/beat_idx of the pending beat.
  - BUSY repeats while stall=1.
  - The first cycle with stall=0 drives SEQ.
  - stall is ignored for NONSEQ beats and for SINGLE bursts.
- **HREADY=0:** HTRANS, HADDR, HBURST, HSIZE and beat_idx hold unchanged. stall is ignored while HREADY=0.
- **Last beat:** when the last beat is on the bus and HREADY=1, the FSM goes to IDLE. The next cycle has HTRANS=IDLE, done=1, req_ready=1.
- **Registration:** HBURST and HSIZE are registered at acceptance and held for the whole burst. In IDLE they keep their last value.

## Timing
- **Reset values:** HTRANS=IDLE, HADDR=0, HBURST=0, HSIZE=0, beat_idx=0, req_ready=1, done=0, req_err=0, FSM=IDLE.
- **Reset mid-burst:** the burst is abandoned immediately (asynchronous) with no done pulse.
- **Acceptance latency:** acceptance edge N puts NONSEQ on the bus during cycle N..N+1.
- **Back-to-back bursts:**
  - There is at least one IDLE cycle between bursts.
  - A request is accepted on the edge ending the IDLE/done cycle, so its NONSEQ follows the IDLE cycle.
- **Duration:** minimum burst duration is beats cycles, plus HREADY-low cycles, plus BUSY cycles.
- **Simultaneous events:** req_valid during ACTIVE is not accepted (req_ready=0). Done and a new acceptance may occur in the same cycle.
- **Pulse exclusivity:** req_err and done are never both high.

## Test plan
- **INCR4:** INCR4 WORD at 0x100, HREADY=1 -> HADDR 0x100,0x104,0x108,0x10C. HTRANS NONSEQ,SEQ,SEQ,SEQ. Then IDLE with done=1.
- **Wrapping bursts:**
  - WRAP4 WORD at 0x38 -> 0x38,0x3C,0x30,0x34.
  - WRAP8 HALF_WORD at 0x1006 -> 0x1006,0x1008,0x100A,0x100C,0x100E,0x1000,0x1002,0x1004.
- **INCR across 1 KB:** INCR len=6 WORD at 0x3F8 -> 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404/0x408/0x40C SEQ. done after beat_idx=5.
- **Back-pressure:**
  - INCR4 at 0x0 with HREADY=0 for 3 cycles on beat 1 -> 0x4/SEQ held 4 cycles.
  - stall=1 for 2 cycles before beat 2 -> two BUSY cycles with HADDR=0x8, then SEQ 0x8.
- **Rejected requests:**
  - WORD at 0x102 -> req_err one cycle, HTRANS stays IDLE.
  - INCR8 WORD at 0x3F0 -> req_err.
  - INCR len=0 -> req_err.
- **Reset mid-burst:** HRESET asserted at beat 2 of WRAP16 -> outputs at reset values immediately, no done. After release a SINGLE at 0x20 -> NONSEQ 0x20 then done.

Source files
------------

// File: rtl/ahb_burst_addr_gen.sv
// AHB master address-phase sequencer: turns one burst request into a beat-by-beat
// HTRANS/HADDR stream with HREADY back-pressure, BUSY insertion and 1 KB page handling.
module ahb_burst_addr_gen #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [2:0]            req_burst,
   input  logic [2:0]            req_size,
   input  logic [7:0]            req_len,
   input  logic                  stall,
   input  logic                  HREADY,
   output logic [1:0]            HTRANS,
   output logic [ADDR_WIDTH-1:0] HADDR,
   output logic [2:0]            HBURST,
   output logic [2:0]            HSIZE,
   output logic [7:0]            beat_idx,
   output logic                  done,
   output logic                  req_err
);

   localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

   typedef enum logic [1:0] {
      T_IDLE   = 2'b00,
      T_BUSY   = 2'b01,
      T_NONSEQ = 2'b10,
      T_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t                state;
   logic [7:0]            beats;

   logic [7:0]            req_beats;
   logic [ADDR_WIDTH-1:0] req_inc;
   logic [11:0]           span_end;
   logic                  fixed_incr;
   logic                  req_bad;

   logic [ADDR_WIDTH-1:0] inc;
   logic [ADDR_WIDTH-1:0] bound;
   logic [ADDR_WIDTH-1:0] incr_addr;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  wrap;
   logic                  next_nonseq;
   logic                  last;

   always_comb begin
      case (req_burst)
         3'd0:       req_beats = 8'd1;
         3'd1:       req_beats = req_len;
         3'd2, 3'd3: req_beats = 8'd4;
         3'd4, 3'd5: req_beats = 8'd8;
         default:    req_beats = 8'd16;
      endcase
   end

   // Span check is done on the in-page offset only; a fixed INCRx never exceeds 64 bytes.
   always_comb begin
      req_inc    = ADDR_WIDTH'(1) << req_size;
      span_end   = {2'b00, req_addr[9:0]} + (12'(req_beats) << req_size[1:0]);
      fixed_incr = (req_burst == 3'd3) || (req_burst == 3'd5) || (req_burst == 3'd7);
      req_bad    = (req_size > MAX_SIZE)
                || ((req_addr & (req_inc - ADDR_WIDTH'(1))) != '0)
                || ((req_burst == 3'd1) && (req_len == 8'd0))
                || (fixed_incr && (span_end > 12'd1024));
   end

   always_comb begin
      inc         = ADDR_WIDTH'(1) << HSIZE;
      bound       = ADDR_WIDTH'(beats) << HSIZE;
      incr_addr   = HADDR + inc;
      wrap        = (HBURST == 3'd2) || (HBURST == 3'd4) || (HBURST == 3'd6);
      next_addr   = wrap ? ((HADDR & ~(bound - ADDR_WIDTH'(1))) | (incr_addr & (bound - ADDR_WIDTH'(1))))
                         : incr_addr;
      next_nonseq = (HBURST == 3'd1) && (next_addr[9:0] == 10'd0);
      last        = (beat_idx == beats - 8'd1);
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state     <= S_IDLE;
         HTRANS    <= T_IDLE;
         HADDR     <= '0;
         HBURST    <= '0;
         HSIZE     <= '0;
         beat_idx  <= '0;
         beats     <= '0;
         req_ready <= 1'b1;
         done      <= 1'b0;
         req_err   <= 1'b0;
      end else begin
         done    <= 1'b0;
         req_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  if (req_bad) begin
                     req_err <= 1'b1;
                  end else begin
                     state     <= S_ACTIVE;
                     req_ready <= 1'b0;
                     HTRANS    <= T_NONSEQ;
                     HADDR     <= req_addr;
                     HBURST    <= req_burst;
                     HSIZE     <= req_size;
                     beats     <= req_beats;
                     beat_idx  <= '0;
                  end
               end
            end
            S_ACTIVE: begin
               if (HREADY) begin
                  // A BUSY cycle already carries the pending beat's address and index.
                  if (HTRANS == T_BUSY) begin
                     HTRANS <= stall ? T_BUSY : T_SEQ;
                  end else if (last) begin
                     state     <= S_IDLE;
                     HTRANS    <= T_IDLE;
                     done      <= 1'b1;
                     req_ready <= 1'b1;
                  end else begin
                     HADDR    <= next_addr;
                     beat_idx <= beat_idx + 8'd1;
                     if (next_nonseq)
                        HTRANS <= T_NONSEQ;
                     else if (stall)
                        HTRANS <= T_BUSY;
                     else
                        HTRANS <= T_SEQ;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
